// File: rtl/uno_pkg.sv
// Shared definitions for the uno sequencer: op codes, FSM states and the
// Horner coefficient tables used by the nonlinear ops.
package uno_pkg;

  localparam int unsigned UNO_MAC_BW = 12;
  localparam int unsigned UNO_DEG    = 3;

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_EXP = 2'b10;
  localparam logic [1:0] OP_LOG = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StPoly,
    StWait
  } uno_state_e;

  // Index 0 is the coefficient used on the first Horner step.
  localparam logic [UNO_MAC_BW-1:0] DIV_COEFF [UNO_DEG] = '{12'h2AB, 12'h155, 12'h0AA};
  localparam logic [UNO_MAC_BW-1:0] EXP_COEFF [UNO_DEG] = '{12'h100, 12'h080, 12'h02B};
  localparam logic [UNO_MAC_BW-1:0] LOG_COEFF [UNO_DEG] = '{12'h0FF, 12'hF80, 12'h055};

endpackage

// File: rtl/uno_seq_if.sv
// Operand stream, PE control and result channel bundle for uno_seq.
// master = operand feeder / PE / result sink side, slave = the sequencer.
interface uno_seq_if #(
  parameter int unsigned MAC_BW = 12
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [1:0]            s_op;
  logic [MAC_BW-1:0]     s_x;
  logic [MAC_BW-1:0]     s_y;
  logic [2*MAC_BW-1:0]   s_z;
  logic                  s_last;

  logic [1:0]            pe_op;
  logic [MAC_BW-1:0]     pe_x;
  logic [MAC_BW-1:0]     pe_y;
  logic [2*MAC_BW-1:0]   pe_z;
  logic [MAC_BW-1:0]     pe_coeff;
  logic                  pe_first_cycle;
  logic                  pe_last_cycle;
  logic                  pe_acc_en;
  logic [2*MAC_BW-1:0]   pe_o;

  logic                  r_valid;
  logic                  r_ready;
  logic [2*MAC_BW-1:0]   r_data;

  modport master (
    output s_valid, s_op, s_x, s_y, s_z, s_last,
    input  s_ready,
    input  pe_op, pe_x, pe_y, pe_z, pe_coeff, pe_first_cycle, pe_last_cycle, pe_acc_en,
    output pe_o,
    input  r_valid, r_data,
    output r_ready
  );

  modport slave (
    input  s_valid, s_op, s_x, s_y, s_z, s_last,
    output s_ready,
    output pe_op, pe_x, pe_y, pe_z, pe_coeff, pe_first_cycle, pe_last_cycle, pe_acc_en,
    input  pe_o,
    output r_valid, r_data,
    input  r_ready
  );

endinterface

// File: rtl/uno_coeff_rom.sv
// Combinational Horner coefficient lookup by (op, step); MAC and
// out-of-range steps return zero.
module uno_coeff_rom
  import uno_pkg::*;
#(
  parameter int unsigned MAC_BW = UNO_MAC_BW,
  parameter int unsigned StepW  = 2
) (
  input  logic [1:0]        i_op,
  input  logic [StepW-1:0]  i_step,
  output logic [MAC_BW-1:0] o_coeff
);

  always_comb begin
    o_coeff = '0;
    for (int unsigned k = 0; k < UNO_DEG; k++) begin
      if (32'(i_step) == k) begin
        case (i_op)
          OP_DIV:  o_coeff = MAC_BW'(DIV_COEFF[k]);
          OP_EXP:  o_coeff = MAC_BW'(EXP_COEFF[k]);
          OP_LOG:  o_coeff = MAC_BW'(LOG_COEFF[k]);
          default: o_coeff = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/uno_seq.sv
// Sequencer for one uno PE: streams MAC groups, steps Horner polynomials for
// nonlinear ops and buffers the PE result behind a valid/ready channel.
module uno_seq
  import uno_pkg::*;
#(
  parameter int unsigned MAC_BW  = UNO_MAC_BW,
  parameter int unsigned DEG     = UNO_DEG,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uno_seq_if.slave bus
);

  localparam int unsigned StepW = $clog2(DEG);
  localparam int unsigned LatW  = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
  localparam int unsigned ResW  = 2 * MAC_BW;

  uno_state_e        r_state;
  logic [StepW-1:0]  r_step;
  logic [LatW-1:0]   r_lat;

  logic [1:0]        r_pe_op;
  logic [MAC_BW-1:0] r_pe_x;
  logic [MAC_BW-1:0] r_pe_y;
  logic [ResW-1:0]   r_pe_z;
  logic [MAC_BW-1:0] r_pe_coeff;
  logic              r_pe_first;
  logic              r_pe_last;
  logic              r_pe_acc_en;
  logic              r_res_valid;
  logic [ResW-1:0]   r_res_data;

  logic              w_buf_free;
  logic              w_s_ready;
  logic              w_accept;
  logic              w_capture;
  logic [1:0]        w_rom_op;
  logic [StepW-1:0]  w_rom_step;
  logic [MAC_BW-1:0] w_coeff;

  assign w_buf_free = !r_res_valid || bus.r_ready;
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_capture  = (r_state == StWait) && (r_lat == LatW'(MAC_LAT));

  always_comb begin
    w_s_ready = 1'b0;
    case (r_state)
      StIdle:  w_s_ready = w_buf_free;
      StMac:   w_s_ready = 1'b1;
      default: w_s_ready = 1'b0;
    endcase
  end

  // Coefficient for the step being loaded into the PE registers this edge.
  always_comb begin
    w_rom_op   = r_pe_op;
    w_rom_step = r_step + 1'b1;
    if (r_state == StIdle) begin
      w_rom_op   = bus.s_op;
      w_rom_step = '0;
    end
  end

  uno_coeff_rom #(
    .MAC_BW (MAC_BW),
    .StepW  (StepW)
  ) u_coeff_rom (
    .i_op    (w_rom_op),
    .i_step  (w_rom_step),
    .o_coeff (w_coeff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_lat       <= '0;
      r_pe_op     <= OP_MAC;
      r_pe_x      <= '0;
      r_pe_y      <= '0;
      r_pe_z      <= '0;
      r_pe_coeff  <= '0;
      r_pe_first  <= 1'b0;
      r_pe_last   <= 1'b0;
      r_pe_acc_en <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      // PE sees an idle, non-accumulating beat unless a state says otherwise.
      r_pe_op     <= OP_MAC;
      r_pe_x      <= '0;
      r_pe_y      <= '0;
      r_pe_z      <= '0;
      r_pe_coeff  <= '0;
      r_pe_first  <= 1'b0;
      r_pe_last   <= 1'b0;
      r_pe_acc_en <= 1'b0;
      if (r_res_valid && bus.r_ready) begin
        r_res_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_pe_x <= bus.s_x;
            r_pe_y <= bus.s_y;
            r_lat  <= '0;
            if (bus.s_op == OP_MAC) begin
              r_pe_z  <= bus.s_z;
              r_state <= bus.s_last ? StWait : StMac;
            end else begin
              r_pe_op    <= bus.s_op;
              r_pe_coeff <= w_coeff;
              r_pe_first <= 1'b1;
              r_step     <= '0;
              r_state    <= StPoly;
            end
          end
        end

        StMac: begin
          r_pe_acc_en <= 1'b1;
          if (bus.s_valid) begin
            r_pe_x <= bus.s_x;
            r_pe_y <= bus.s_y;
            if (bus.s_last) begin
              r_lat   <= '0;
              r_state <= StWait;
            end
          end
        end

        StPoly: begin
          r_pe_op    <= r_pe_op;
          r_pe_x     <= r_pe_x;
          r_pe_y     <= r_pe_y;
          r_pe_coeff <= w_coeff;
          r_step     <= r_step + 1'b1;
          // Leave on the edge that loads the final step so the latency count
          // starts from the same point as for a MAC last beat.
          if (r_step == StepW'(DEG - 2)) begin
            r_pe_last <= 1'b1;
            r_lat     <= '0;
            r_state   <= StWait;
          end
        end

        StWait: begin
          r_lat <= r_lat + 1'b1;
          if (w_capture) begin
            r_res_data  <= bus.pe_o;
            r_res_valid <= 1'b1;
            r_lat       <= '0;
            r_step      <= '0;
            r_state     <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.s_ready        = w_s_ready;
  assign bus.pe_op          = r_pe_op;
  assign bus.pe_x           = r_pe_x;
  assign bus.pe_y           = r_pe_y;
  assign bus.pe_z           = r_pe_z;
  assign bus.pe_coeff       = r_pe_coeff;
  assign bus.pe_first_cycle = r_pe_first;
  assign bus.pe_last_cycle  = r_pe_last;
  assign bus.pe_acc_en      = r_pe_acc_en;
  assign bus.r_valid        = r_res_valid;
  assign bus.r_data         = r_res_data;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq with a one-cycle-latency PE model
// (MAC accumulate, Horner acc = acc*x + coeff for nonlinear ops).
module tb_uno_seq;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  uno_seq_if #(.MAC_BW(12)) bus ();

  uno_seq #(
    .MAC_BW  (12),
    .DEG     (3),
    .MAC_LAT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] pe_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_acc <= '0;
    end else if (bus.pe_op == 2'b00) begin
      pe_acc <= (bus.pe_acc_en ? pe_acc : bus.pe_z) + (24'(bus.pe_x) * 24'(bus.pe_y));
    end else begin
      pe_acc <= (bus.pe_first_cycle ? 24'd0 : (pe_acc * 24'(bus.pe_x))) + 24'(bus.pe_coeff);
    end
  end
  assign bus.pe_o = pe_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                       input logic [23:0] z, input logic last);
    bus.s_valid = 1'b1;
    bus.s_op    = op;
    bus.s_x     = x;
    bus.s_y     = y;
    bus.s_z     = z;
    bus.s_last  = last;
    #1;
  endtask

  task automatic idle_in();
    bus.s_valid = 1'b0;
    bus.s_op    = 2'b00;
    bus.s_x     = '0;
    bus.s_y     = '0;
    bus.s_z     = '0;
    bus.s_last  = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.r_ready = 1'b1;
    idle_in();
    tick();
    tick();
    check_eq("rst_r_valid", 32'(bus.r_valid), 32'd0);
    check_eq("rst_acc_en", 32'(bus.pe_acc_en), 32'd0);
    check_eq("rst_first", 32'(bus.pe_first_cycle), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_s_ready", 32'(bus.s_ready), 32'd1);

    // MAC group (2,3),(4,5),(1,1), z=10 -> 37
    drive(2'b00, 12'd2, 12'd3, 24'd10, 1'b0);
    tick();
    check_eq("mac_b1_acc_en", 32'(bus.pe_acc_en), 32'd0);
    check_eq("mac_b1_z", 32'(bus.pe_z), 32'd10);
    check_eq("mac_b1_x", 32'(bus.pe_x), 32'd2);
    drive(2'b00, 12'd4, 12'd5, 24'd0, 1'b0);
    tick();
    check_eq("mac_b2_acc_en", 32'(bus.pe_acc_en), 32'd1);
    check_eq("mac_b2_x", 32'(bus.pe_x), 32'd4);
    drive(2'b00, 12'd1, 12'd1, 24'd0, 1'b1);
    tick();
    check_eq("mac_b3_acc_en", 32'(bus.pe_acc_en), 32'd1);
    idle_in();
    check_eq("mac_wait_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check_eq("mac_t2_r_valid", 32'(bus.r_valid), 32'd0);
    check_eq("mac_t2_pe_x", 32'(bus.pe_x), 32'd0);
    tick();
    check_eq("mac_t3_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("mac_t3_r_data", 32'(bus.r_data), 32'd37);
    tick();
    check_eq("mac_drain_r_valid", 32'(bus.r_valid), 32'd0);

    // Same group with a two-cycle bubble after beat 1
    drive(2'b00, 12'd2, 12'd3, 24'd10, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("gap_pe_x", 32'(bus.pe_x), 32'd0);
      check_eq("gap_pe_y", 32'(bus.pe_y), 32'd0);
      check_eq("gap_acc_en", 32'(bus.pe_acc_en), 32'd1);
    end
    drive(2'b00, 12'd4, 12'd5, 24'd0, 1'b0);
    tick();
    drive(2'b00, 12'd1, 12'd1, 24'd0, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    check_eq("gap_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("gap_r_data", 32'(bus.r_data), 32'd37);
    tick();

    // Exp, x=2: coeffs 0x100,0x080,0x02B -> 256, 640, 1323
    drive(2'b10, 12'd2, 12'd5, 24'd99, 1'b1);
    tick();
    idle_in();
    check_eq("exp_c1_first", 32'(bus.pe_first_cycle), 32'd1);
    check_eq("exp_c1_last", 32'(bus.pe_last_cycle), 32'd0);
    check_eq("exp_c1_coeff", 32'(bus.pe_coeff), 32'h100);
    check_eq("exp_c1_op", 32'(bus.pe_op), 32'd2);
    check_eq("exp_c1_z", 32'(bus.pe_z), 32'd0);
    check_eq("exp_c1_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check_eq("exp_c2_first", 32'(bus.pe_first_cycle), 32'd0);
    check_eq("exp_c2_last", 32'(bus.pe_last_cycle), 32'd0);
    check_eq("exp_c2_coeff", 32'(bus.pe_coeff), 32'h080);
    check_eq("exp_c2_x", 32'(bus.pe_x), 32'd2);
    check_eq("exp_c2_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check_eq("exp_c3_last", 32'(bus.pe_last_cycle), 32'd1);
    check_eq("exp_c3_coeff", 32'(bus.pe_coeff), 32'h02B);
    check_eq("exp_c3_acc_en", 32'(bus.pe_acc_en), 32'd0);
    check_eq("exp_c3_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check_eq("exp_c4_r_valid", 32'(bus.r_valid), 32'd0);
    check_eq("exp_c4_last", 32'(bus.pe_last_cycle), 32'd0);
    check_eq("exp_c4_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check_eq("exp_c5_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("exp_c5_r_data", 32'(bus.r_data), 32'd1323);
    tick();

    // Backpressure: 5*6+100 = 130 held, next beat (3*4+0) blocked
    bus.r_ready = 1'b0;
    drive(2'b00, 12'd5, 12'd6, 24'd100, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    drive(2'b00, 12'd3, 12'd4, 24'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_r_valid", 32'(bus.r_valid), 32'd1);
      check_eq("bp_r_data", 32'(bus.r_data), 32'd130);
      check_eq("bp_s_ready", 32'(bus.s_ready), 32'd0);
      tick();
    end
    bus.r_ready = 1'b1;
    #1;
    check_eq("bp_release_s_ready", 32'(bus.s_ready), 32'd1);
    tick();
    idle_in();
    check_eq("bp_drained_r_valid", 32'(bus.r_valid), 32'd0);
    check_eq("bp_next_x", 32'(bus.pe_x), 32'd3);
    tick();
    tick();
    check_eq("bp_next_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("bp_next_r_data", 32'(bus.r_data), 32'd12);
    tick();

    // Reset during step 1 of a log op, then single-beat MAC 3*3+1
    drive(2'b11, 12'd3, 12'd0, 24'd0, 1'b0);
    tick();
    idle_in();
    tick();
    check_eq("log_c2_coeff", 32'(bus.pe_coeff), 32'hF80);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_coeff", 32'(bus.pe_coeff), 32'd0);
    check_eq("rst_mid_op", 32'(bus.pe_op), 32'd0);
    check_eq("rst_mid_x", 32'(bus.pe_x), 32'd0);
    check_eq("rst_mid_r_valid", 32'(bus.r_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
    drive(2'b00, 12'd3, 12'd3, 24'd1, 1'b1);
    tick();
    idle_in();
    check_eq("post_rst_acc_en", 32'(bus.pe_acc_en), 32'd0);
    tick();
    tick();
    check_eq("post_rst_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("post_rst_r_data", 32'(bus.r_data), 32'd10);
    tick();

    // Later beats carrying op 01 stay MAC: 1*2 + 3*4 + 2*2 = 18
    drive(2'b00, 12'd1, 12'd2, 24'd0, 1'b0);
    tick();
    drive(2'b01, 12'd3, 12'd4, 24'd0, 1'b0);
    tick();
    check_eq("opig_b2_op", 32'(bus.pe_op), 32'd0);
    check_eq("opig_b2_first", 32'(bus.pe_first_cycle), 32'd0);
    check_eq("opig_b2_acc_en", 32'(bus.pe_acc_en), 32'd1);
    drive(2'b01, 12'd2, 12'd2, 24'd0, 1'b1);
    tick();
    idle_in();
    check_eq("opig_b3_op", 32'(bus.pe_op), 32'd0);
    check_eq("opig_b3_first", 32'(bus.pe_first_cycle), 32'd0);
    tick();
    check_eq("opig_wait_first", 32'(bus.pe_first_cycle), 32'd0);
    tick();
    check_eq("opig_r_valid", 32'(bus.r_valid), 32'd1);
    check_eq("opig_r_data", 32'(bus.r_data), 32'd18);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uno_seq.md
# uno_seq

Sequencer for the `uno` processing element: it turns a valid/ready operand stream into the per-cycle control and operand pattern the PE needs. For multiply-accumulate (MAC) groups it issues one beat per cycle. For divide, exp and log it holds X/Y and steps a Horner polynomial of `DEG` terms, driving `coeff`, `first_cycle` and `last_cycle`. It captures the PE accumulator output into a one-entry result buffer with valid/ready. It sits between the array operand feeder and one `uno` instance.

## Interface
- `MAC_BW`, 12: PE operand width; results are 2*`MAC_BW`.
- `DEG`, 3: polynomial steps per nonlinear op, ≥2.
- `MAC_LAT`, 1: cycles from PE input to PE `oC` valid.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `s_valid` in 1: operand beat valid.
- `s_ready` out 1: beat accepted when `s_valid && s_ready` at `clk` rise.
- `s_op` in 2: 00 MAC, 01 div, 10 exp, 11 log.
- `s_x`, `s_y` in `MAC_BW`: operands.
- `s_z` in 2*`MAC_BW`: MAC initial accumulator (first beat of group only).
- `s_last` in 1: last beat of MAC group; ignored for nonlinear ops.
- `pe_op` out 2; `pe_x`, `pe_y` out `MAC_BW`; `pe_z` out 2*`MAC_BW`; `pe_coeff` out `MAC_BW`; `pe_first_cycle`, `pe_last_cycle`, `pe_acc_en` out 1: registered PE controls.
- `pe_o` in 2*`MAC_BW`: PE MAC output.
- `r_valid` out 1, `r_ready` in 1, `r_data` out 2*`MAC_BW`: result channel.

## Operation
- FSM states:
  - IDLE: `s_ready` = buffer free. Beat with op 00 → MAC. Op ≠00 → POLY with step=0.
  - MAC: `s_ready`=1.
    - A beat with `s_last`=1 → WAIT.
    - `s_op` is sampled on the group's first beat only; later beats' `s_op` is ignored.
  - POLY: `s_ready`=0. The step counter increments each cycle; step=`DEG`-1 → WAIT.
  - WAIT: `s_ready`=0. Counts `MAC_LAT`, then captures `pe_o` → `r_data`, sets `r_valid` → IDLE.
- MAC beat drive:
  - `pe_x`=`s_x`, `pe_y`=`s_y`.
  - First beat: `pe_acc_en`=0 and `pe_z`=`s_z`. Later beats: `pe_acc_en`=1.
  - `pe_first_cycle`=`pe_last_cycle`=0.
- MAC bubble (MAC state, `s_valid`=0): drive `pe_x`=`pe_y`=0 with `pe_acc_en`=1, so the accumulator holds.
- Nonlinear drive:
  - `pe_op`, `pe_x` and `pe_y` are held from the accepted beat for `DEG` cycles.
  - `pe_coeff` = ROM(op, step).
  - `pe_first_cycle`=1 at step 0 only; `pe_last_cycle`=1 at step `DEG`-1 only.
  - `pe_acc_en`=0 and `pe_z`=0.
- IDLE/WAIT drive: all `pe_*`=0 (op 00, no accumulate).
- Buffer-free condition: `!r_valid || r_ready`. The first beat of an operation is accepted only when the buffer is free. The buffer is never overwritten.
- Reset (any time, including mid-group): state IDLE, counters 0, all outputs 0, `r_valid`=0. Any partial accumulation is discarded.

## Timing
- Beat accepted at edge t → its `pe_*` values appear in cycle t+1.
- MAC result: last beat accepted at t → `r_valid`=1 from cycle t+2+`MAC_LAT`.
- Nonlinear result: beat accepted at t → `pe_first_cycle` in cycle t+1, `pe_last_cycle` in cycle t+`DEG`, `r_valid`=1 from cycle t+`DEG`+1+`MAC_LAT`.
- `r_valid`/`r_data` stay stable until `r_ready`. `r_valid` falls the cycle after the handshake unless a new capture occurs on the same edge.
- Simultaneous capture and `r_ready`: the new result loads and `r_valid` stays 1.
- Back-to-back:
  - MAC beats within a group: 1 per cycle.
  - A new operation is accepted in the first IDLE cycle after WAIT, provided the buffer is free.
- Single-beat MAC group (first beat with `s_last`=1): `pe_acc_en`=0, result = `s_x`*`s_y`+`s_z`.

## Structure
- Package `uno_pkg` holds:
  - op encoding constants (`OP_MAC`, `OP_DIV`, `OP_EXP`, `OP_LOG`);
  - FSM state enum;
  - per-op coefficient arrays [`DEG`][`MAC_BW`].
- Sub-module `uno_coeff_rom`: combinational (op, step) → coeff, reading `uno_pkg` arrays. MAC returns 0.
- The top level holds the FSM, step and latency counters, `pe_*` output registers and the result buffer.

## Test plan
- MAC group of 3 beats, (x,y) = (2,3),(4,5),(1,1), z=10, `MAC_LAT`=1, `r_ready`=1:
  - `pe_acc_en` = 0,1,1;
  - `r_data`=37;
  - `r_valid` in cycle t+3 after the last beat.
- Same group with a 2-cycle `s_valid` gap after beat 1: zero operands with `acc_en`=1 during the gap, `r_data`=37.
- Exp beat, `DEG`=3:
  - `pe_first_cycle` high in cycle 1 only; `pe_last_cycle` high in cycle 3 only;
  - `pe_coeff` = ROM(10,0..2) in order;
  - `s_ready`=0 throughout;
  - `r_valid` at t+5.
- Result backpressure: `r_ready`=0 for 10 cycles after a result → `r_data` stable; next op's first beat is not accepted until the cycle `r_ready`=1.
- `rst_n` pulsed low during step 1 of a log op → all outputs 0 immediately; a following MAC single beat (3,3,z=1) gives 10.
- A MAC group whose later beats carry `s_op`=01 → treated as MAC; `pe_first_cycle` never asserted.
